mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the RV32I pipeline, directly downstream of the execute-stage ALU.
- Takes the ALU result as a load/store effective address, or as a pass-through writeback value for non-memory instructions.
- Drives a single-ported data-memory request/ack interface, including byte-lane alignment, sign/zero extension and misalignment detection.
- Hands one registered result per instruction to writeback over a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_ADDR_WIDTH, 5, width of the destination register index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  execute stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_alu_result  input  XLEN  ALU result: address for memory ops, writeback data otherwise.
- in_store_data  input  XLEN  rs2 value for stores.
- in_mem_read  input  1  instruction is a load.
- in_mem_write  input  1  instruction is a store; never high together with in_mem_read.
- in_funct3  input  3  access size/sign field.
- in_rd  input  REG_ADDR_WIDTH  destination register.
- in_reg_write  input  1  instruction writes rd.
- dmem_req  output  1  memory request; held until ack.
- dmem_we  output  1  1 = store.
- dmem_addr  output  XLEN  word-aligned address, i.e. {addr[31:2],2'b00}.
- dmem_wdata  output  XLEN  lane-replicated store data.
- dmem_be  output  XLEN/8  byte enables.
- dmem_ack  input  1  request completed; dmem_rdata valid this cycle for loads.
- dmem_rdata  input  XLEN  read word.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts.
- out_data  output  XLEN  writeback value.
- out_rd  output  REG_ADDR_WIDTH  destination register.
- out_reg_write  output  1  write enable for rd.
- out_exc  output  1  misaligned/illegal access flag.

Behaviour:
- Reset (rst_n low at clk edge):
  - State goes to IDLE.
  - dmem_req, dmem_we, out_valid, out_reg_write and out_exc go to 0.
  - dmem_addr, dmem_wdata, dmem_be, out_data and out_rd go to 0.
  - Reset overrides everything, including an outstanding request. A dmem_ack arriving after reset is ignored.
- States: IDLE, MEM_WAIT.
- Ready and accept:
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational.
  - Accept = in_valid && in_ready.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - Clears out_valid on out_ready unless it is reloaded in the same cycle.
- Non-memory accept (in_mem_read == in_mem_write == 0):
  - Next cycle: out_valid=1, out_data=in_alu_result, out_rd=in_rd, out_reg_write=in_reg_write, out_exc=0.
  - State stays IDLE. Latency is 1 cycle, giving full throughput.
- Memory op legality, checked on accept:
  - funct3 000 (LB/SB) and 100 (LBU): always legal.
  - 001 (LH/SH) and 101 (LHU): require addr[0]==0.
  - 010 (LW/SW): requires addr[1:0]==0.
  - 011, 110, 111: illegal. For stores, 100 and 101 are also illegal.
- Illegal or misaligned memory op:
  - No memory request is issued.
  - Next cycle: out_valid=1, out_exc=1, out_reg_write=0, out_data=in_alu_result (faulting address). State stays IDLE.
- Legal memory op:
  - Next cycle: dmem_req=1, dmem_we=in_mem_write, dmem_addr word-aligned.
  - dmem_be = 4'b0001<<a (byte), 4'b0011<<a (half), 4'b1111 (word), where a = addr[1:0].
  - dmem_wdata = {4{sd[7:0]}}, {2{sd[15:0]}} or sd, where sd is in_store_data.
  - The byte offset, funct3, rd and reg_write are latched internally. State goes to MEM_WAIT.
- MEM_WAIT:
  - All dmem_* outputs are held stable until dmem_ack.
  - On a dmem_ack cycle, next cycle: dmem_req=0, state=IDLE, out_valid=1, out_exc=0, out_rd=latched rd.
  - Loads: w = dmem_rdata >> (8*a). out_data = sign-extended w[7:0] (LB), w[15:0] (LH), zero-extended w[7:0] (LBU), w[15:0] (LHU), or w (LW). out_reg_write = latched reg_write.
  - Stores: out_reg_write=0, out_data=0.
- Latency:
  - dmem_ack may be high in the first cycle dmem_req is high, giving a minimum load/store latency of 2 cycles from accept to out_valid.
  - The wait time to ack is unbounded.
- Back-pressure: the output register cannot be overwritten while it holds an unconsumed result, because in_ready blocks new accepts.
- dmem_ack while not in MEM_WAIT is ignored.

Test Plan:
- Non-memory pass-through: in_alu_result=0x0000_1234, rd=5, reg_write=1, out_ready=1 → next cycle out_valid=1, out_data=0x1234, out_rd=5. Back-to-back issue every cycle sustains one result per cycle.
- Load byte signed: LB at addr 0x103, with dmem_rdata=0x80FF_1122 and ack after 3 wait cycles.
  - Required: dmem_addr=0x100 and dmem_be=4'b1000, held until ack.
  - Then out_data=0xFFFF_FF80. Repeating with LBU gives 0x0000_0080.
- Store half: SH at addr 0x202, store_data=0xDEAD_BEEF → dmem_we=1, dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF. After ack: out_valid=1, out_reg_write=0.
- Misaligned: LW at 0x0000_0006 → dmem_req never asserts; next cycle out_exc=1, out_data=0x6, out_reg_write=0.
- Back-pressure: out_ready=0 for 4 cycles after a result → out_* stable and in_ready=0. Raising out_ready gives in_ready=1 in the same cycle, and the next instruction is accepted.
- Reset mid-operation: rst_n=0 during MEM_WAIT → next cycle dmem_req=0, out_valid=0, state IDLE. A late dmem_ack produces no output.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : RV32I memory-access stage. Issues aligned data-memory
//               requests with byte lanes, extracts and extends load data,
//               flags misaligned/illegal accesses, and hands one registered
//               result per instruction to writeback over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // execute-stage side
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_alu_result,
  input  logic [XLEN-1:0]           in_store_data,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic [2:0]                in_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_reg_write,
  // data-memory side
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [XLEN-1:0]           dmem_wdata,
  output logic [XLEN/8-1:0]         dmem_be,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_rdata,
  // writeback side
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  output logic                      out_exc
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t                    state;

  // Per-access context kept while the memory request is outstanding
  logic [1:0]                lat_off;
  logic [2:0]                lat_funct3;
  logic [REG_ADDR_WIDTH-1:0] lat_rd;
  logic                      lat_reg_write;

  logic                      accept;
  logic                      is_mem;
  logic                      legal;
  logic [1:0]                byte_off;
  logic [XLEN/8-1:0]         be_next;
  logic [XLEN-1:0]           wdata_next;
  logic [XLEN-1:0]           load_word;
  logic [XLEN-1:0]           load_value;

  // New work only enters when idle and the result slot is free or draining
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_mem_read || in_mem_write;
  assign byte_off = in_alu_result[1:0];

  // Access legality: size must be natural-aligned; unsigned forms are load-only
  always_comb begin
    legal = 1'b0;
    case (in_funct3)
      3'b000:  legal = 1'b1;
      3'b100:  legal = !in_mem_write;
      3'b001:  legal = !byte_off[0];
      3'b101:  legal = !in_mem_write && !byte_off[0];
      3'b010:  legal = (byte_off == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data by access size
  always_comb begin
    be_next    = {(XLEN/8){1'b1}};
    wdata_next = in_store_data;
    case (in_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << byte_off;
        wdata_next = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << byte_off;
        wdata_next = {2{in_store_data[15:0]}};
      end
      default: begin
        be_next    = {(XLEN/8){1'b1}};
        wdata_next = in_store_data;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend per load kind
  assign load_word = dmem_rdata >> {lat_off, 3'b000};

  // Load result formatting (sign/zero extension)
  always_comb begin
    load_value = load_word;
    case (lat_funct3)
      3'b000:  load_value = {{(XLEN-8){load_word[7]}}, load_word[7:0]};
      3'b001:  load_value = {{(XLEN-16){load_word[15]}}, load_word[15:0]};
      3'b100:  load_value = {{(XLEN-8){1'b0}}, load_word[7:0]};
      3'b101:  load_value = {{(XLEN-16){1'b0}}, load_word[15:0]};
      default: load_value = load_word;
    endcase
  end

  // Stage control FSM with registered memory-request and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_exc       <= 1'b0;
      lat_off       <= '0;
      lat_funct3    <= '0;
      lat_rd        <= '0;
      lat_reg_write <= 1'b0;
    end else begin
      // Consumed result drops; any reload below takes priority
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              out_valid     <= 1'b1;
              out_data      <= in_alu_result;
              out_rd        <= in_rd;
              out_reg_write <= in_reg_write;
              out_exc       <= 1'b0;
            end else if (!legal) begin
              // Faulting address is reported in place of a result
              out_valid     <= 1'b1;
              out_data      <= in_alu_result;
              out_rd        <= in_rd;
              out_reg_write <= 1'b0;
              out_exc       <= 1'b1;
            end else begin
              dmem_req      <= 1'b1;
              dmem_we       <= in_mem_write;
              dmem_addr     <= {in_alu_result[XLEN-1:2], 2'b00};
              dmem_be       <= be_next;
              dmem_wdata    <= wdata_next;
              lat_off       <= byte_off;
              lat_funct3    <= in_funct3;
              lat_rd        <= in_rd;
              lat_reg_write <= in_reg_write;
              state         <= MEM_WAIT;
            end
          end
        end

        MEM_WAIT: begin
          // Request outputs stay frozen until the memory acknowledges
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            state     <= IDLE;
            out_valid <= 1'b1;
            out_exc   <= 1'b0;
            out_rd    <= lat_rd;
            if (dmem_we) begin
              out_data      <= '0;
              out_reg_write <= 1'b0;
            end else begin
              out_data      <= load_value;
              out_reg_write <= lat_reg_write;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
